usr_tx_ctrl: RTL and testbench
==============================

USR_TX_CTRL -- requirements
Module: usr_tx_ctrl

Interface
REQ-001 Parameter CLKS_PER_BIT, 16, CLK cycles per serial bit; legal range 2..65535.
REQ-002 Parameter PARITY_ODD, 0, 0 selects even parity and 1 selects odd parity.
REQ-003 CLK  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 RST_N  in  1  reset; synchronous, active-low.
REQ-005 tx_data  in  8  byte to transmit.
REQ-006 tx_valid  in  1  tx_data is offered for transmission.
REQ-007 tx_ready  out  1  controller can accept a byte.
REQ-008 usr_sel  out  2  shift-register mode select: 00 hold, 01 shift right, 11 parallel load; 10 is never driven.
REQ-009 usr_par  out  8  parallel-load value for the shift register; equals tx_data.
REQ-010 usr_ser_out  in  1  shift-register LSB (current data bit).
REQ-011 tx_line  out  1  registered serial line output; idle level is 1.
REQ-012 frame_done  out  1  one-cycle pulse at the end of a frame.

Function
REQ-013 States SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-014 tx_ready SHALL be 1 only in IDLE; accept occurs when tx_valid and tx_ready are both 1.
REQ-015 On the accept cycle, usr_sel SHALL be 11 (combinational), parity SHALL be latched from tx_data, and the state SHALL go to START.
REQ-016 Each of START, PARITY and STOP SHALL last exactly CLKS_PER_BIT cycles; DATA SHALL last 8*CLKS_PER_BIT cycles.
REQ-017 tx_line SHALL lag the state by one cycle: start bit 0, data bit usr_ser_out, parity bit, stop bit 1, and 1 in IDLE.
REQ-018 Data SHALL be sent LSB first.
REQ-019 In DATA, usr_sel SHALL be 01 for exactly one cycle, the last cycle of each bit period, for all 8 bits.
REQ-020 In all other cycles usr_sel SHALL be 00.
REQ-021 A 3-bit bit counter SHALL count 0..7; DATA SHALL exit to PARITY when the counter is 7 at the end of a bit period.
REQ-022 The parity bit SHALL be the XOR of tx_data bits, inverted when PARITY_ODD is 1.
REQ-023 The bit timer SHALL count 0..CLKS_PER_BIT-1, wrap to 0 at every bit boundary, and be 16 bits wide.
REQ-024 On the last STOP cycle the state SHALL return to IDLE and frame_done SHALL pulse in that same cycle.
REQ-025 Back-to-back frames: the earliest next accept SHALL be the cycle after frame_done, so the stop bit is never shortened.
REQ-026 Changes to tx_valid or tx_data after accept SHALL be ignored until IDLE.
REQ-027 If tx_valid is held high continuously, frames SHALL repeat with tx_line never dropping to 0 outside start bits.

Reset
REQ-028 While RST_N is 0 at a CLK edge, the block SHALL set: state IDLE, tx_line 1, usr_sel 00, frame_done 0, timer 0, bit counter 0.
REQ-029 A reset mid-frame SHALL abort the frame: tx_line 1 on the next cycle, no frame_done pulse, and tx_ready 1 after release.
REQ-030 Outputs SHALL be defined on the first CLK edge with RST_N low; no asynchronous paths.

Configuration
REQ-031 Macro USR_TX_CTRL_PARITY_EN: when defined, the PARITY state SHALL be included and the frame is 11 bits.
REQ-032 Without USR_TX_CTRL_PARITY_EN, DATA SHALL go directly to STOP, the frame is 10 bits, and PARITY_ODD SHALL be ignored.

Structure
REQ-033 A shared package usr_tx_pkg SHALL hold the state enum and the usr_sel encodings: SEL_HOLD, SEL_SHR, SEL_LOAD.
REQ-034 One sub-module, usr_bit_timer, SHALL contain the CLKS_PER_BIT timer and produce a bit_end strobe.
REQ-035 The shift register SHALL be external; this block only sequences it.

Verification
REQ-036 Parity enabled, CLKS_PER_BIT=4, even parity, send 0xA5 -> tx_line 0,1,0,1,0,0,1,0,1,0,1, each held 4 cycles, 44 cycles total, one frame_done pulse.
REQ-037 Same setup, odd parity, send 0x00 -> parity bit 1; send 0xFF -> parity bit 1.
REQ-038 Parity disabled, send 0x3C -> 10-bit frame of 40 cycles, no parity slot, exactly 8 usr_sel=01 pulses.
REQ-039 tx_valid held high with 0x55 then 0xAA -> second start bit immediately follows the stop bit, and tx_ready is high for exactly one cycle between frames.
REQ-040 RST_N low in cycle 10 of DATA -> next cycle tx_line 1 and usr_sel 00, no frame_done pulse; a new accept after release produces a correct frame.
REQ-041 tx_data changed mid-frame -> transmitted bits match the byte latched at accept.

Source files
------------

// File: rtl/usr_tx_pkg.sv
// Shared definitions for the serial TX sequencer: FSM state codes and the
// external shift-register mode-select encodings.
package usr_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic [2:0] ST_IDLE   = IDLE;
  localparam logic [2:0] ST_START  = START;
  localparam logic [2:0] ST_DATA   = DATA;
  localparam logic [2:0] ST_PARITY = PARITY;
  localparam logic [2:0] ST_STOP   = STOP;

  // 2'b10 is never driven onto usr_sel.
  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_SHR  = 2'b01;
  localparam logic [1:0] SEL_LOAD = 2'b11;

endpackage

// File: rtl/usr_tx_ctrl_if.sv
// Byte handshake plus external shift-register control and serial line.
// slave = the TX controller, master = the byte source / shift-register side.
interface usr_tx_ctrl_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [1:0] usr_sel;
  logic [7:0] usr_par;
  logic       usr_ser_out;
  logic       tx_line;
  logic       frame_done;

  modport slave (
    input  tx_data, tx_valid, usr_ser_out,
    output tx_ready, usr_sel, usr_par, tx_line, frame_done
  );

  modport master (
    output tx_data, tx_valid, usr_ser_out,
    input  tx_ready, usr_sel, usr_par, tx_line, frame_done
  );
endinterface

// File: rtl/usr_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled, o_bit_end on the last count.
// Zero latency strobe; held at 0 while disabled, no backpressure.
module usr_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic i_en,
  output logic o_bit_end
);
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

  logic [15:0] r_cnt;

  assign o_bit_end = i_en && (r_cnt == LAST);

  always_ff @(posedge CLK) begin
    if (!RST_N || !i_en) begin
      r_cnt <= 16'd0;
    end else if (o_bit_end) begin
      r_cnt <= 16'd0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/usr_tx_ctrl.sv
// Serial TX sequencer driving an external shift register; parity slot built with USR_TX_CTRL_PARITY_EN.
// tx_line lags state by one cycle; tx_ready only in IDLE, so the source is held off for a whole frame.
module usr_tx_ctrl
  import usr_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic         CLK,
  input  logic         RST_N,
  usr_tx_ctrl_if.slave bus
);
  logic [2:0] r_state;
  logic [2:0] w_state_nxt;
  logic [2:0] r_bit_cnt;
  logic       r_tx_line;
  logic       w_bit_end;
  logic       w_accept;
  logic       w_timer_en;
  logic       w_last_bit;

  assign w_accept   = (r_state == ST_IDLE) && bus.tx_valid;
  assign w_timer_en = (r_state != ST_IDLE);
  assign w_last_bit = w_bit_end && (r_bit_cnt == 3'd7);

  usr_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .i_en      (w_timer_en),
    .o_bit_end (w_bit_end)
  );

`ifdef USR_TX_CTRL_PARITY_EN
  logic r_parity;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_parity <= 1'b0;
    end else if (w_accept) begin
      r_parity <= (^bus.tx_data) ^ PARITY_ODD;
    end
  end
`else
  logic w_unused_par;
  assign w_unused_par = PARITY_ODD;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept)   w_state_nxt = ST_START;
      ST_START:  if (w_bit_end)  w_state_nxt = ST_DATA;
`ifdef USR_TX_CTRL_PARITY_EN
      ST_DATA:   if (w_last_bit) w_state_nxt = ST_PARITY;
      ST_PARITY: if (w_bit_end)  w_state_nxt = ST_STOP;
`else
      ST_DATA:   if (w_last_bit) w_state_nxt = ST_STOP;
`endif
      ST_STOP:   if (w_bit_end)  w_state_nxt = ST_IDLE;
      default:                   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Wraps 7 -> 0 on the final data bit, so it is ready for the next frame.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_bit_cnt <= 3'd0;
    end else if ((r_state == ST_DATA) && w_bit_end) begin
      r_bit_cnt <= r_bit_cnt + 3'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_tx_line <= 1'b1;
    end else begin
      case (r_state)
        ST_START:  r_tx_line <= 1'b0;
        ST_DATA:   r_tx_line <= bus.usr_ser_out;
`ifdef USR_TX_CTRL_PARITY_EN
        ST_PARITY: r_tx_line <= r_parity;
`endif
        default:   r_tx_line <= 1'b1;
      endcase
    end
  end

  // The external register shifts on the edge that closes each data bit period.
  always_comb begin
    bus.usr_sel = SEL_HOLD;
    if (w_accept) begin
      bus.usr_sel = SEL_LOAD;
    end else if ((r_state == ST_DATA) && w_bit_end) begin
      bus.usr_sel = SEL_SHR;
    end
  end

  assign bus.tx_ready   = (r_state == ST_IDLE);
  assign bus.usr_par    = bus.tx_data;
  assign bus.tx_line    = r_tx_line;
  // Gated by RST_N so a reset landing on the last stop cycle aborts silently.
  assign bus.frame_done = RST_N && (r_state == ST_STOP) && w_bit_end;

endmodule

// File: tb/tb_usr_tx_ctrl.sv
`timescale 1ns/1ps
module tb_usr_tx_ctrl;
  localparam int N = 4;
`ifdef USR_TX_CTRL_PARITY_EN
  localparam int NBITS     = 11;
  localparam int FRAME_CYC = 44;
  localparam logic [0:10] LIT_A5 = 11'b01010010101;
`else
  localparam int NBITS     = 10;
  localparam int FRAME_CYC = 40;
  localparam logic [0:9]  LIT_A5 = 10'b0101001011;
`endif

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;

  always #5 CLK = ~CLK;

  usr_tx_ctrl_if if_e();
  usr_tx_ctrl_if if_o();

  assign if_e.tx_data  = tx_data;
  assign if_e.tx_valid = tx_valid;
  assign if_o.tx_data  = tx_data;
  assign if_o.tx_valid = tx_valid;

  usr_tx_ctrl #(.CLKS_PER_BIT(N), .PARITY_ODD(1'b0)) u_dut_even (
    .CLK(CLK), .RST_N(RST_N), .bus(if_e.slave));
  usr_tx_ctrl #(.CLKS_PER_BIT(N), .PARITY_ODD(1'b1)) u_dut_odd (
    .CLK(CLK), .RST_N(RST_N), .bus(if_o.slave));

  // External shift registers (environment, not a model of the DUT)
  logic [7:0] sr_e = 8'h00;
  logic [7:0] sr_o = 8'h00;
  always @(posedge CLK) begin
    case (if_e.usr_sel)
      2'b11:   sr_e <= if_e.usr_par;
      2'b01:   sr_e <= {1'b0, sr_e[7:1]};
      default: sr_e <= sr_e;
    endcase
    case (if_o.usr_sel)
      2'b11:   sr_o <= if_o.usr_par;
      2'b01:   sr_o <= {1'b0, sr_o[7:1]};
      default: sr_o <= sr_o;
    endcase
  end
  assign if_e.usr_ser_out = sr_e[0];
  assign if_o.usr_ser_out = sr_o[0];

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected line level for frame slot k (0 start, 1..8 data LSB first, parity, stop)
  function automatic logic exp_slot(input logic [7:0] b, input int k, input bit odd);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[3'(k - 1)];
`ifdef USR_TX_CTRL_PARITY_EN
    if (k == 9) return (^b) ^ odd;
`endif
    return 1'b1;
  endfunction

  // Behavioural model: offset since accept determines every output.
  bit         m_busy = 1'b0;
  int         m_d = 0;
  logic [7:0] m_byte = 8'h00;
  logic [1:0] m_line = 2'b11;

  always @(negedge CLK) begin : cmp
    logic       e_rdy, e_done;
    logic [1:0] e_sel, cur;
    int         pos, slot, ph;
    e_rdy = 1'b1; e_done = 1'b0; e_sel = 2'b00; cur = 2'b11;
    pos = 0; slot = 0; ph = 0;
    if (!m_busy) begin
      e_sel = tx_valid ? 2'b11 : 2'b00;
    end else begin
      e_rdy  = 1'b0;
      pos    = m_d - 1;
      slot   = pos / N;
      ph     = pos % N;
      e_done = RST_N && (pos == NBITS * N - 1);
      if (slot >= 1 && slot <= 8 && ph == N - 1) e_sel = 2'b01;
      cur = {exp_slot(m_byte, slot, 1'b1), exp_slot(m_byte, slot, 1'b0)};
    end
    if (chk_en) begin
      chk("line_even", 32'(if_e.tx_line), 32'(m_line[0]));
      chk("line_odd", 32'(if_o.tx_line), 32'(m_line[1]));
      chk("done_even", 32'(if_e.frame_done), 32'(e_done));
      chk("done_odd", 32'(if_o.frame_done), 32'(e_done));
      if (RST_N) begin
        chk("ready_even", 32'(if_e.tx_ready), 32'(e_rdy));
        chk("ready_odd", 32'(if_o.tx_ready), 32'(e_rdy));
        chk("sel_even", 32'(if_e.usr_sel), 32'(e_sel));
        chk("sel_odd", 32'(if_o.usr_sel), 32'(e_sel));
        chk("usr_par", 32'(if_e.usr_par), 32'(tx_data));
      end
    end
    if (!RST_N) begin
      m_busy = 1'b0; m_d = 0; m_line = 2'b11;
    end else begin
      m_line = cur;
      if (!m_busy) begin
        if (tx_valid) begin m_busy = 1'b1; m_d = 1; m_byte = tx_data; end
      end else if (e_done) begin
        m_busy = 1'b0;
      end else begin
        m_d++;
      end
    end
  end

  logic       cap_le   [48];
  logic       cap_lo   [48];
  logic       cap_done [48];
  logic [1:0] cap_sel  [48];

  task automatic wait_ready(input string nm);
    int w = 0;
    while (!if_e.tx_ready && w < 200) begin @(posedge CLK); #1; w++; end
    chk(nm, 32'(if_e.tx_ready), 32'd1);
  endtask

  // Offer byte b for one cycle, scramble tx_data afterwards, record 48 cycles.
  task automatic send_capture(input logic [7:0] b);
    @(posedge CLK); #1;
    wait_ready("cap_ready_wait");
    tx_data = b; tx_valid = 1'b1;
    for (int i = 0; i < 48; i++) begin
      @(negedge CLK);
      cap_le[i] = if_e.tx_line; cap_lo[i] = if_o.tx_line;
      cap_done[i] = if_e.frame_done; cap_sel[i] = if_e.usr_sel;
      if (i == 0) begin @(posedge CLK); #1; tx_valid = 1'b0; tx_data = ~b; end
    end
  endtask

  task automatic verify(input string tag, input logic [7:0] b);
    int nd = 0, first = -1, ns = 0;
    for (int i = 0; i < 48; i++) begin
      if (cap_done[i]) begin nd++; if (first < 0) first = i; end
      if (cap_sel[i] == 2'b01) ns++;
    end
    chk({tag, "_done_count"}, 32'(nd), 32'd1);
    chk({tag, "_frame_cycles"}, 32'(first), 32'(FRAME_CYC));
    chk({tag, "_shift_pulses"}, 32'(ns), 32'd8);
    chk({tag, "_load_sel"}, 32'(cap_sel[0]), 32'd3);
    for (int k = 0; k < NBITS; k++) begin
      chk({tag, "_slot_even"}, 32'(cap_le[3 + N * k]), 32'(exp_slot(b, k, 1'b0)));
      chk({tag, "_slot_odd"}, 32'(cap_lo[3 + N * k]), 32'(exp_slot(b, k, 1'b1)));
    end
  endtask

  initial begin
    int  rdy, gap, nd;
    bit  found;
    repeat (3) @(posedge CLK);
    #1;
    chk_en = 1'b1;
    chk("reset_line", 32'(if_e.tx_line), 32'd1);
    chk("reset_sel", 32'(if_e.usr_sel), 32'd0);
    chk("reset_done", 32'(if_e.frame_done), 32'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;

    send_capture(8'hA5);
    verify("a5", 8'hA5);
    for (int k = 0; k < NBITS; k++)
      chk("a5_literal", 32'(cap_le[3 + N * k]), 32'(LIT_A5[k]));

    send_capture(8'h00);
    chk("odd_par_00", 32'(cap_lo[3 + N * 9]), 32'd1);
    send_capture(8'hFF);
    chk("odd_par_ff", 32'(cap_lo[3 + N * 9]), 32'd1);
    verify("ff", 8'hFF);

    send_capture(8'h3C);
    verify("3c", 8'h3C);

    // Back-to-back with tx_valid held high
    @(posedge CLK); #1;
    wait_ready("b2b_ready_wait");
    tx_data = 8'h55; tx_valid = 1'b1;
    @(posedge CLK); #1;
    tx_data = 8'hAA;
    gap = 0; found = 1'b0;
    while (gap < 100 && !found) begin @(negedge CLK); gap++; if (if_e.frame_done) found = 1'b1; end
    chk("b2b_first_done", 32'(found), 32'd1);
    rdy = 0; gap = 0; found = 1'b0;
    while (gap < 100 && !found) begin
      @(negedge CLK); gap++;
      if (if_e.tx_ready) rdy++;
      if (if_e.frame_done) found = 1'b1;
    end
    chk("b2b_second_done", 32'(found), 32'd1);
    chk("b2b_ready_cycles", 32'(rdy), 32'd1);
    chk("b2b_done_gap", 32'(gap), 32'(FRAME_CYC + 1));
    @(posedge CLK); #1;
    tx_valid = 1'b0;

    // Reset in DATA (cycle index 15 after accept)
    @(posedge CLK); #1;
    wait_ready("rst_ready_wait");
    tx_data = 8'h96; tx_valid = 1'b1;
    @(posedge CLK); #1;
    tx_valid = 1'b0;
    repeat (14) begin @(posedge CLK); #1; end
    RST_N = 1'b0;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    chk("abort_line", 32'(if_e.tx_line), 32'd1);
    chk("abort_sel", 32'(if_e.usr_sel), 32'd0);
    chk("abort_ready", 32'(if_e.tx_ready), 32'd1);
    nd = 0;
    repeat (50) begin @(negedge CLK); if (if_e.frame_done) nd++; end
    chk("abort_no_done", 32'(nd), 32'd0);
    send_capture(8'hC3);
    verify("after_rst", 8'hC3);

    // Randomized traffic with occasional resets, checked by the model
    for (int c = 0; c < 3000; c++) begin
      @(posedge CLK); #1;
      tx_valid = ($urandom_range(0, 3) == 0);
      tx_data  = 8'($urandom);
      RST_N    = ($urandom_range(0, 399) != 0);
    end
    @(posedge CLK); #1;
    RST_N = 1'b1; tx_valid = 1'b0;
    repeat (60) @(posedge CLK);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
